// File: rtl/rupt_priority_if.sv
// SQ-side rupt handshake between the priority controller and the sequencer.
// The sequencer drives the strobes; the controller returns request, vector and status.
interface rupt_priority_if #(
   parameter int IDX_W = 4
);
   logic             nisq;
   logic             krpt;
   logic             resume;
   logic             ruptor_n;
   logic [IDX_W-1:0] rupt_idx;
   logic [11:0]      rupt_addr;
   logic             in_rupt;

   modport master (
      output nisq, krpt, resume,
      input  ruptor_n, rupt_idx, rupt_addr, in_rupt
   );

   modport slave (
      input  nisq, krpt, resume,
      output ruptor_n, rupt_idx, rupt_addr, in_rupt
   );
endinterface

// File: rtl/rupt_priority.sv
// RUPT priority controller: latches requests, gates them with inhibits and hands the SQ
// the highest-priority vector on krpt. Optional rupt lock alarm under `RUPT_LOCK_EN.
module rupt_priority #(
   parameter int          N_RUPT      = 10,
   parameter int          IDX_W       = 4,
   parameter logic [11:0] VEC_BASE    = 12'o4000,
   parameter int          ACK_TIMEOUT = 16,
   parameter int          LOCK_LIMIT  = 4096
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              gojam,
   input  logic [N_RUPT-1:0] rupt_req,
   input  logic              inhlpls,
   input  logic              relpls,
   input  logic              ovnhrp,
   input  logic              mnhrpt,
   rupt_priority_if.slave    sq,
   output logic [N_RUPT-1:0] pend,
   output logic              rupt_lost,
   output logic              rupt_lock_alarm
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      SVC  = 2'd3
   } state_t;

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

   state_t            state_r, state_nx_s;
   logic [N_RUPT-1:0] pend_r, clr_s;
   logic              inhint_r;
   logic              elig_s, take_s, lost_s;
   logic [IDX_W-1:0]  sel_idx_s;
   logic [TO_W-1:0]   to_cnt_r, to_cnt_nx_s;
   logic              ruptor_n_r, in_rupt_r, rupt_lost_r;
   logic [IDX_W-1:0]  rupt_idx_r;
   logic [11:0]       rupt_addr_r;

   // Lowest-numbered set bit wins (bit 0 is highest priority).
   function automatic logic [IDX_W-1:0] first_set(input logic [N_RUPT-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = N_RUPT - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
         else      idx = idx;
      end
      return idx;
   endfunction

   function automatic logic [11:0] vec_addr(input logic [IDX_W-1:0] idx);
      return VEC_BASE + ({{(12-IDX_W){1'b0}}, idx} << 2'd2);
   endfunction

   assign elig_s    = (|pend_r) & ~inhint_r & ~ovnhrp & ~mnhrpt;
   assign sel_idx_s = first_set(pend_r);
   assign clr_s     = take_s ? ({{(N_RUPT-1){1'b0}}, 1'b1} << sel_idx_s) : {N_RUPT{1'b0}};

   // Next-state, acknowledge timeout and take/lost decisions.
   always_comb begin
      state_nx_s  = state_r;
      take_s      = 1'b0;
      lost_s      = 1'b0;
      to_cnt_nx_s = to_cnt_r;
      case (state_r)
         IDLE: begin
            if (elig_s) state_nx_s = REQ;
            else        state_nx_s = IDLE;
         end
         REQ: begin
            if (!elig_s) begin
               state_nx_s = IDLE;
            end else if (sq.nisq) begin
               state_nx_s  = ACK;
               to_cnt_nx_s = {TO_W{1'b0}};
            end else begin
               state_nx_s = REQ;
            end
         end
         ACK: begin
            if (sq.krpt) begin
               state_nx_s = SVC;
               take_s     = 1'b1;
            end else if (to_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
               state_nx_s = IDLE;
               lost_s     = 1'b1;
            end else begin
               to_cnt_nx_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         SVC: begin
            if (sq.resume) state_nx_s = IDLE;
            else           state_nx_s = SVC;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State, pending/inhibit flops and registered SQ outputs; gojam clears like reset.
   always_ff @(posedge clock) begin
      if (!rst_n || gojam) begin
         state_r     <= IDLE;
         pend_r      <= {N_RUPT{1'b0}};
         inhint_r    <= 1'b0;
         to_cnt_r    <= {TO_W{1'b0}};
         ruptor_n_r  <= 1'b1;
         in_rupt_r   <= 1'b0;
         rupt_lost_r <= 1'b0;
         rupt_idx_r  <= {IDX_W{1'b0}};
         rupt_addr_r <= VEC_BASE;
      end else begin
         state_r     <= state_nx_s;
         pend_r      <= (pend_r & ~clr_s) | rupt_req;
         inhint_r    <= inhlpls | (inhint_r & ~relpls);
         to_cnt_r    <= to_cnt_nx_s;
         ruptor_n_r  <= ~((state_nx_s == REQ) || (state_nx_s == ACK));
         rupt_lost_r <= lost_s;
         if (take_s) begin
            rupt_idx_r  <= sel_idx_s;
            rupt_addr_r <= vec_addr(sel_idx_s);
            in_rupt_r   <= 1'b1;
         end else if ((state_r == SVC) && sq.resume) begin
            in_rupt_r   <= 1'b0;
         end else begin
            in_rupt_r   <= in_rupt_r;
         end
      end
   end

`ifdef RUPT_LOCK_EN
   localparam int LK_W = $clog2(LOCK_LIMIT + 1);
   logic [LK_W-1:0] lock_cnt_r;
   logic            lock_alarm_r;

   // Service-time counter; alarm latches when a single service reaches LOCK_LIMIT.
   always_ff @(posedge clock) begin
      if (!rst_n || gojam) begin
         lock_cnt_r   <= {LK_W{1'b0}};
         lock_alarm_r <= 1'b0;
      end else if ((state_r == SVC) && (state_nx_s == SVC)) begin
         if (lock_cnt_r != LK_W'(LOCK_LIMIT)) lock_cnt_r <= lock_cnt_r + {{(LK_W-1){1'b0}}, 1'b1};
         else                                 lock_cnt_r <= lock_cnt_r;
         if (lock_cnt_r == LK_W'(LOCK_LIMIT - 1)) lock_alarm_r <= 1'b1;
         else                                     lock_alarm_r <= lock_alarm_r;
      end else begin
         lock_cnt_r   <= {LK_W{1'b0}};
         lock_alarm_r <= lock_alarm_r;
      end
   end

   assign rupt_lock_alarm = lock_alarm_r;
`else
   assign rupt_lock_alarm = 1'b0;
`endif

   assign sq.ruptor_n  = ruptor_n_r;
   assign sq.in_rupt   = in_rupt_r;
   assign sq.rupt_idx  = rupt_idx_r;
   assign sq.rupt_addr = rupt_addr_r;
   assign pend         = pend_r;
   assign rupt_lost    = rupt_lost_r;

endmodule

// File: tb/tb_rupt_priority.sv
// Bench for rupt_priority: directed vector table, then random stimulus against a
// behavioural model of the rupt rules.
module tb_rupt_priority;

   localparam logic [8:0] RST = 9'h100, G  = 9'h080, INH = 9'h040, REL = 9'h020,
                          OV  = 9'h010, MN = 9'h008, NQ  = 9'h004, KR  = 9'h002,
                          RS  = 9'h001;

   logic       clock = 1'b0;
   logic       rst_n, gojam, inhlpls, relpls, ovnhrp, mnhrpt;
   logic [9:0] rupt_req, pend;
   logic       rupt_lost, rupt_lock_alarm;

   rupt_priority_if #(.IDX_W(4)) sq ();

   rupt_priority dut (
      .clock           (clock),
      .rst_n           (rst_n),
      .gojam           (gojam),
      .rupt_req        (rupt_req),
      .inhlpls         (inhlpls),
      .relpls          (relpls),
      .ovnhrp          (ovnhrp),
      .mnhrpt          (mnhrpt),
      .sq              (sq),
      .pend            (pend),
      .rupt_lost       (rupt_lost),
      .rupt_lock_alarm (rupt_lock_alarm)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [9:0] req;
      logic [8:0] ctl;
      logic       e_rn;
      logic       e_in;
      logic [3:0] e_idx;
      logic [9:0] e_pend;
      logic       e_lost;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // behavioural model: flags for "asking", "awaiting krpt", "in service"
   bit [9:0]  m_pend;
   bit        m_inhint, m_asking, m_waiting, m_serving, m_lost, m_alarm;
   int        m_age, m_idx, m_svc_len;
   bit [11:0] m_addr;

   function automatic void add(input logic [9:0] req, input logic [8:0] ctl, input logic rn,
                               input logic inr, input logic [3:0] idx, input logic [9:0] pd,
                               input logic lost);
      vec_t v;
      v.req = req; v.ctl = ctl; v.e_rn = rn; v.e_in = inr;
      v.e_idx = idx; v.e_pend = pd; v.e_lost = lost;
      tbl.push_back(v);
   endfunction

   task automatic apply(input logic [9:0] req, input logic [8:0] ctl);
      rupt_req  = req;
      rst_n     = ~ctl[8];
      gojam     = ctl[7];
      inhlpls   = ctl[6];
      relpls    = ctl[5];
      ovnhrp    = ctl[4];
      mnhrpt    = ctl[3];
      sq.nisq   = ctl[2];
      sq.krpt   = ctl[1];
      sq.resume = ctl[0];
   endtask

   task automatic model_step();
      bit elig, was_serving;
      int pick;
      was_serving = m_serving;
      m_lost = 1'b0;
      if (!rst_n || gojam) begin
         m_pend = '0; m_inhint = 0; m_asking = 0; m_waiting = 0; m_serving = 0;
         m_age = 0; m_idx = 0; m_addr = 12'o4000; m_alarm = 0; m_svc_len = 0;
         return;
      end
      elig = (m_pend != 10'd0) && !m_inhint && !ovnhrp && !mnhrpt;
      pick = -1;
      if (m_serving) begin
         if (sq.resume) m_serving = 0;
      end else if (m_waiting) begin
         if (sq.krpt) begin
            for (int i = 9; i >= 0; i--) if (m_pend[i]) pick = i;
            m_idx = pick;
            m_addr = 12'o4000 + 12'(4 * pick);
            m_waiting = 0;
            m_serving = 1;
         end else begin
            m_age++;
            if (m_age == 16) begin
               m_waiting = 0;
               m_lost = 1;
            end
         end
      end else if (m_asking) begin
         if (!elig) m_asking = 0;
         else if (sq.nisq) begin
            m_asking = 0; m_waiting = 1; m_age = 0;
         end
      end else if (elig) begin
         m_asking = 1;
      end
      if (pick >= 0) m_pend[pick] = 1'b0;
      m_pend = m_pend | rupt_req;
      m_inhint = inhlpls | (m_inhint & ~relpls);
`ifdef RUPT_LOCK_EN
      if (was_serving && m_serving) begin
         m_svc_len++;
         if (m_svc_len == 4096) m_alarm = 1;
      end else begin
         m_svc_len = 0;
      end
`else
      m_svc_len = was_serving ? 0 : 0;
`endif
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at vector %0d: got 0x%0h, expected 0x%0h", name, n_vec, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      model_step();
      #1;
      n_vec++;
   endtask

   initial begin
      // Directed table: expected outputs after the edge that samples each row
      add(10'h000, RST,      1, 0, 0, 10'h000, 0);
      add(10'h000, 9'h000,   1, 0, 0, 10'h000, 0);
      add(10'h008, 9'h000,   1, 0, 0, 10'h008, 0);
      add(10'h000, 9'h000,   0, 0, 0, 10'h008, 0);
      add(10'h000, NQ,       0, 0, 0, 10'h008, 0);
      add(10'h000, 9'h000,   0, 0, 0, 10'h008, 0);
      add(10'h000, KR,       1, 1, 3, 10'h000, 0);
      add(10'h022, 9'h000,   1, 1, 3, 10'h022, 0);
      add(10'h000, RS,       1, 0, 3, 10'h022, 0);
      add(10'h000, 9'h000,   0, 0, 3, 10'h022, 0);
      add(10'h000, NQ,       0, 0, 3, 10'h022, 0);
      add(10'h000, KR,       1, 1, 1, 10'h020, 0);
      add(10'h000, RS,       1, 0, 1, 10'h020, 0);
      add(10'h000, 9'h000,   0, 0, 1, 10'h020, 0);
      add(10'h000, NQ,       0, 0, 1, 10'h020, 0);
      add(10'h000, KR,       1, 1, 5, 10'h000, 0);
      add(10'h000, RS,       1, 0, 5, 10'h000, 0);
      add(10'h000, INH,      1, 0, 5, 10'h000, 0);
      add(10'h001, 9'h000,   1, 0, 5, 10'h001, 0);
      add(10'h000, 9'h000,   1, 0, 5, 10'h001, 0);
      add(10'h000, 9'h000,   1, 0, 5, 10'h001, 0);
      add(10'h000, REL,      1, 0, 5, 10'h001, 0);
      add(10'h000, 9'h000,   0, 0, 5, 10'h001, 0);
      add(10'h000, INH|REL,  0, 0, 5, 10'h001, 0);
      add(10'h000, 9'h000,   1, 0, 5, 10'h001, 0);
      add(10'h000, REL,      1, 0, 5, 10'h001, 0);
      add(10'h000, 9'h000,   0, 0, 5, 10'h001, 0);
      add(10'h000, NQ,       0, 0, 5, 10'h001, 0);
      for (int i = 0; i < 15; i++) add(10'h000, 9'h000, 0, 0, 5, 10'h001, 0);
      add(10'h000, 9'h000,   1, 0, 5, 10'h001, 1);
      add(10'h080, 9'h000,   0, 0, 5, 10'h081, 0);
      add(10'h000, NQ,       0, 0, 5, 10'h081, 0);
      add(10'h000, KR,       1, 1, 0, 10'h080, 0);
      add(10'h000, RS,       1, 0, 0, 10'h080, 0);
      add(10'h000, 9'h000,   0, 0, 0, 10'h080, 0);
      add(10'h000, NQ,       0, 0, 0, 10'h080, 0);
      add(10'h000, KR,       1, 1, 7, 10'h000, 0);
      add(10'h010, 9'h000,   1, 1, 7, 10'h010, 0);
      add(10'h000, G,        1, 0, 0, 10'h000, 0);
      add(10'h000, 9'h000,   1, 0, 0, 10'h000, 0);
      add(10'h200, OV,       1, 0, 0, 10'h200, 0);
      add(10'h000, OV,       1, 0, 0, 10'h200, 0);
      add(10'h000, MN,       1, 0, 0, 10'h200, 0);
      add(10'h000, 9'h000,   0, 0, 0, 10'h200, 0);
      add(10'h000, MN,       1, 0, 0, 10'h200, 0);
      add(10'h000, 9'h000,   0, 0, 0, 10'h200, 0);
      add(10'h000, NQ,       0, 0, 0, 10'h200, 0);
      add(10'h000, OV|KR,    1, 1, 9, 10'h000, 0);
      add(10'h000, KR|NQ,    1, 1, 9, 10'h000, 0);
      add(10'h000, RS,       1, 0, 9, 10'h000, 0);
      add(10'h000, RS|KR,    1, 0, 9, 10'h000, 0);
      add(10'h004, 9'h000,   1, 0, 9, 10'h004, 0);
      add(10'h000, 9'h000,   0, 0, 9, 10'h004, 0);
      add(10'h000, NQ,       0, 0, 9, 10'h004, 0);
      add(10'h004, KR,       1, 1, 2, 10'h004, 0);
      add(10'h000, RS,       1, 0, 2, 10'h004, 0);
      add(10'h000, 9'h000,   0, 0, 2, 10'h004, 0);

      foreach (tbl[k]) begin
         apply(tbl[k].req, tbl[k].ctl);
         cyc();
         check("ruptor_n",  32'(sq.ruptor_n),  32'(tbl[k].e_rn));
         check("in_rupt",   32'(sq.in_rupt),   32'(tbl[k].e_in));
         check("rupt_idx",  32'(sq.rupt_idx),  32'(tbl[k].e_idx));
         check("rupt_addr", 32'(sq.rupt_addr), 32'(12'o4000 + 12'(4 * tbl[k].e_idx)));
         check("pend",      32'(pend),         32'(tbl[k].e_pend));
         check("rupt_lost", 32'(rupt_lost),    32'(tbl[k].e_lost));
         check("lock_alarm", 32'(rupt_lock_alarm), 32'd0);
      end

      // Random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rupt_req  = ($urandom_range(0, 7) == 0) ? (10'd1 << $urandom_range(0, 9)) : 10'd0;
         rst_n     = 1'b1;
         gojam     = ($urandom_range(0, 399) == 0);
         inhlpls   = ($urandom_range(0, 31) == 0);
         relpls    = ($urandom_range(0, 15) == 0);
         ovnhrp    = ($urandom_range(0, 19) == 0);
         mnhrpt    = ($urandom_range(0, 19) == 0);
         sq.nisq   = ($urandom_range(0, 2) == 0);
         sq.krpt   = ($urandom_range(0, 4) == 0);
         sq.resume = ($urandom_range(0, 5) == 0);
         cyc();
         check("rnd ruptor_n",  32'(sq.ruptor_n),  32'(!(m_asking || m_waiting)));
         check("rnd in_rupt",   32'(sq.in_rupt),   32'(m_serving));
         check("rnd rupt_idx",  32'(sq.rupt_idx),  32'(m_idx));
         check("rnd rupt_addr", 32'(sq.rupt_addr), 32'(m_addr));
         check("rnd pend",      32'(pend),         32'(m_pend));
         check("rnd rupt_lost", 32'(rupt_lost),    32'(m_lost));
         check("rnd lock_alarm", 32'(rupt_lock_alarm), 32'(m_alarm));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
